ldmx_dtm_tx_scheduler: RTL

//  Schedules 10-bit timing codes onto one COB timing TX lane (txDataA/txDataAEn/txReadyA).

---
 rtl/ldmx_dtm_tx_scheduler.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/ldmx_dtm_tx_scheduler.sv
// ---------------------------------------------------------------------------
// ldmx_dtm_tx_scheduler
//
// Schedules 10-bit timing codes onto one COB timing TX lane. Three sources
// share the lane with fixed priority: trigger, then periodic sync, then the
// software command. After every sent code the lane is held idle so that
// consecutive txDataEn pulses are at least MIN_GAP+1 cycles apart. Triggers
// that arrive while one is still waiting are dropped and counted.
//
// Ports (all synchronous to distClk):
//   distClk      in   1      lane clock
//   distClkRst   in   1      asynchronous, active-high reset
//   enable       in   1      scheduler enable
//   cntRst       in   1      synchronous clear of trigDropCnt
//   trigReq      in   1      single-cycle trigger request
//   trigCode     in   10     trigger code, sampled with trigReq
//   cmdValid     in   1      software command valid
//   cmdData      in   10     software command code
//   cmdReady     out  1      command accepted this cycle (combinational)
//   txReady      in   1      lane ready (txReadyA)
//   txData       out  10     code to lane (txDataA)
//   txDataEn     out  1      code strobe (txDataAEn)
//   busy         out  1      state != IDLE
//   trigDropCnt  out  CNT_W  dropped-trigger count, saturating
// ---------------------------------------------------------------------------
module ldmx_dtm_tx_scheduler #(
    parameter int         SYNC_PERIOD = 1024,
    parameter logic [9:0] SYNC_CODE   = 10'h3C0,
    parameter int         MIN_GAP     = 4,
    parameter int         CNT_W       = 16
) (
    input  logic             distClk,
    input  logic             distClkRst,
    input  logic             enable,
    input  logic             cntRst,
    input  logic             trigReq,
    input  logic [9:0]       trigCode,
    input  logic             cmdValid,
    input  logic [9:0]       cmdData,
    output logic             cmdReady,
    input  logic             txReady,
    output logic [9:0]       txData,
    output logic             txDataEn,
    output logic             busy,
    output logic [CNT_W-1:0] trigDropCnt
);

    localparam int SYNC_W = $clog2(SYNC_PERIOD);
    localparam int GAP_W  = (MIN_GAP > 1) ? $clog2(MIN_GAP) : 1;

    // The counter is loaded at the grant edge and keeps counting through the
    // SEND cycle. The IDLE cycle in which the next grant happens is itself
    // the last of the MIN_GAP silent cycles, so GAP only covers MIN_GAP-1.
    localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((MIN_GAP > 0) ? MIN_GAP - 1 : 0);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } schedState_t;

    schedState_t       state;
    schedState_t       stateNext;

    logic              trigPend;
    logic [9:0]        trigCodeQ;
    logic              syncPend;
    logic [SYNC_W-1:0] syncCnt;
    logic [GAP_W-1:0]  gapCnt;

    logic              canGrant;
    logic              grantTrig;
    logic              grantSync;
    logic              grantCmd;
    logic              grantAny;
    logic              trigAccept;
    logic              trigDrop;
    logic              syncWrap;

    function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // State register
    always_ff @(posedge distClk or posedge distClkRst) begin
        if (distClkRst) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state logic
    always_comb begin
        stateNext = state;
        case (state)
            IDLE:    if (grantAny) stateNext = SEND;
            SEND:    stateNext = (MIN_GAP > 1) ? GAP : IDLE;
            GAP:     if (gapCnt == '0) stateNext = IDLE;
            default: stateNext = IDLE;
        endcase
    end

    // Output / grant decode
    always_comb begin
        busy      = (state != IDLE);
        canGrant  = (state == IDLE) && enable && txReady;
        grantTrig = canGrant && trigPend;
        grantSync = canGrant && !trigPend && syncPend;
        grantCmd  = canGrant && !trigPend && !syncPend && cmdValid;
        grantAny  = grantTrig || grantSync || grantCmd;
        cmdReady  = grantCmd;
        // A request in the grant cycle refills the latch instead of dropping.
        trigAccept = enable && trigReq && (!trigPend || grantTrig);
        trigDrop   = enable && trigReq && trigPend && !grantTrig;
        syncWrap   = enable && (syncCnt == SYNC_W'(SYNC_PERIOD - 1));
    end

    // Lane output register
    always_ff @(posedge distClk or posedge distClkRst) begin
        if (distClkRst) begin
            txDataEn <= 1'b0;
            txData   <= '0;
        end else if (grantAny) begin
            txDataEn <= 1'b1;
            txData   <= grantTrig ? trigCodeQ : (grantSync ? SYNC_CODE : cmdData);
        end else begin
            txDataEn <= 1'b0;
            txData   <= '0;
        end
    end

    // Gap counter
    always_ff @(posedge distClk or posedge distClkRst) begin
        if (distClkRst) begin
            gapCnt <= '0;
        end else if (grantAny) begin
            gapCnt <= GAP_LOAD;
        end else if ((state != IDLE) && (gapCnt != '0)) begin
            gapCnt <= gapCnt - GAP_W'(1);
        end
    end

    // Trigger latch and drop counter
    always_ff @(posedge distClk or posedge distClkRst) begin
        if (distClkRst) begin
            trigPend    <= 1'b0;
            trigCodeQ   <= '0;
            trigDropCnt <= '0;
        end else begin
            if (trigAccept) begin
                trigPend  <= 1'b1;
                trigCodeQ <= trigCode;
            end else if (grantTrig) begin
                trigPend <= 1'b0;
            end
            if (cntRst) begin
                trigDropCnt <= '0;
            end else if (trigDrop) begin
                trigDropCnt <= satInc(trigDropCnt);
            end
        end
    end

    // Sync period counter; a new wrap wins over a simultaneous sync grant
    always_ff @(posedge distClk or posedge distClkRst) begin
        if (distClkRst) begin
            syncCnt  <= '0;
            syncPend <= 1'b0;
        end else if (!enable) begin
            syncCnt  <= '0;
            syncPend <= 1'b0;
        end else begin
            syncCnt <= syncWrap ? '0 : syncCnt + SYNC_W'(1);
            if (syncWrap) begin
                syncPend <= 1'b1;
            end else if (grantSync) begin
                syncPend <= 1'b0;
            end
        end
    end

endmodule
